// File: rtl/reorder_buffer_pkg.sv
// Shared reorder buffer types and sizing.
// Also supplies the tag width used by the reservation station.
package reorder_buffer_pkg;

   localparam int ROB_DEPTH = 64;
   localparam int IDX_W     = $clog2(ROB_DEPTH);
   localparam int ROB_IDX_W = IDX_W;
   localparam int PREG_W    = 6;
   localparam int NUM_FU    = 3;
   localparam int PC_W      = 32;

   typedef logic [IDX_W-1:0]  rob_idx_t;
   typedef logic [IDX_W:0]    rob_cnt_t;
   typedef logic [PREG_W-1:0] preg_t;
   typedef logic [PC_W-1:0]   pc_t;

   typedef struct packed {
      logic  used;
      logic  completed;
      preg_t destreg;
      preg_t old_destreg;
      pc_t   pc;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, completion and retire bundle of the reorder buffer.
// The master side drives dispatch and completion; the slave side is the ROB.
interface reorder_buffer_if;
   import reorder_buffer_pkg::*;

   logic [1:0]              alloc_req;
   preg_t                   alloc_rd0;
   preg_t                   alloc_rd1;
   preg_t                   alloc_old_rd0;
   preg_t                   alloc_old_rd1;
   pc_t                     alloc_pc0;
   pc_t                     alloc_pc1;
   logic                    alloc_ready;
   rob_idx_t                alloc_idx0;
   rob_idx_t                alloc_idx1;
   logic [NUM_FU-1:0]       cmpl_valid;
   logic [NUM_FU*IDX_W-1:0] cmpl_idx;
   logic [1:0]              retire_valid;
   preg_t                   retire_rd0;
   preg_t                   retire_rd1;
   preg_t                   retire_old_rd0;
   preg_t                   retire_old_rd1;
   pc_t                     retire_pc0;
   pc_t                     retire_pc1;
   rob_cnt_t                count;

   modport master (
      output alloc_req, alloc_rd0, alloc_rd1,
      output alloc_old_rd0, alloc_old_rd1,
      output alloc_pc0, alloc_pc1,
      output cmpl_valid, cmpl_idx,
      input  alloc_ready, alloc_idx0, alloc_idx1,
      input  retire_valid, retire_rd0, retire_rd1,
      input  retire_old_rd0, retire_old_rd1,
      input  retire_pc0, retire_pc1, count
   );

   modport slave (
      input  alloc_req, alloc_rd0, alloc_rd1,
      input  alloc_old_rd0, alloc_old_rd1,
      input  alloc_pc0, alloc_pc1,
      input  cmpl_valid, cmpl_idx,
      output alloc_ready, alloc_idx0, alloc_idx1,
      output retire_valid, retire_rd0, retire_rd1,
      output retire_old_rd0, retire_old_rd1,
      output retire_pc0, retire_pc1, count
   );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: dual dispatch, three completion
// ports, dual in-order retire handing old physical regs to the free list.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input logic             clk,
   input logic             reset,
   input logic             flush,
   reorder_buffer_if.slave rob
);

   rob_entry_t rob_q [ROB_DEPTH];
   rob_idx_t   head_q;
   rob_idx_t   tail_q;
   rob_cnt_t   count_q;

   logic [1:0] rv_q;
   preg_t      rrd0_q;
   preg_t      rrd1_q;
   preg_t      rold0_q;
   preg_t      rold1_q;
   pc_t        rpc0_q;
   pc_t        rpc1_q;

   rob_idx_t   head1;
   rob_idx_t   tail1;
   logic       ready;
   logic       do_alloc;
   logic       do_pair;
   logic       r0;
   logic       r1;
   rob_cnt_t   n_alloc;
   rob_cnt_t   n_ret;
   rob_idx_t   cidx [NUM_FU];

   // Pointer neighbours, allocate/retire decisions from pre-edge state.
   always_comb begin
      head1    = head_q + 1'b1;
      tail1    = tail_q + 1'b1;
      // Ignores same-cycle retirement on purpose: a pair always fits.
      ready    = count_q <= rob_cnt_t'(ROB_DEPTH - 2);
      // 2'b10 has no slot 0 and is dropped entirely.
      do_alloc = ready & rob.alloc_req[0];
      do_pair  = do_alloc & rob.alloc_req[1];
      r0       = rob_q[head_q].used & rob_q[head_q].completed;
      r1       = r0 & rob_q[head1].used & rob_q[head1].completed;
      n_alloc  = rob_cnt_t'(do_alloc) + rob_cnt_t'(do_pair);
      n_ret    = rob_cnt_t'(r0) + rob_cnt_t'(r1);
      for (int k = 0; k < NUM_FU; k++) begin
         cidx[k] = rob.cmpl_idx[k*IDX_W +: IDX_W];
      end
   end

   // Entry array, pointers, occupancy and registered retire outputs.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         rv_q    <= '0;
         rrd0_q  <= '0;
         rrd1_q  <= '0;
         rold0_q <= '0;
         rold1_q <= '0;
         rpc0_q  <= '0;
         rpc1_q  <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            rob_q[i].used      <= 1'b0;
            rob_q[i].completed <= 1'b0;
         end
      end else begin
         // Only live entries may complete; stale tags fall through.
         for (int k = 0; k < NUM_FU; k++) begin
            if (rob.cmpl_valid[k] && rob_q[cidx[k]].used) begin
               rob_q[cidx[k]].completed <= 1'b1;
            end
         end
         if (r0) begin
            rrd0_q                  <= rob_q[head_q].destreg;
            rold0_q                 <= rob_q[head_q].old_destreg;
            rpc0_q                  <= rob_q[head_q].pc;
            rob_q[head_q].used      <= 1'b0;
            rob_q[head_q].completed <= 1'b0;
         end
         if (r1) begin
            rrd1_q                 <= rob_q[head1].destreg;
            rold1_q                <= rob_q[head1].old_destreg;
            rpc1_q                 <= rob_q[head1].pc;
            rob_q[head1].used      <= 1'b0;
            rob_q[head1].completed <= 1'b0;
         end
         // Allocation targets free slots, never a retiring head.
         if (do_alloc) begin
            rob_q[tail_q] <= '{
               used:        1'b1,
               completed:   1'b0,
               destreg:     rob.alloc_rd0,
               old_destreg: rob.alloc_old_rd0,
               pc:          rob.alloc_pc0
            };
         end
         if (do_pair) begin
            rob_q[tail1] <= '{
               used:        1'b1,
               completed:   1'b0,
               destreg:     rob.alloc_rd1,
               old_destreg: rob.alloc_old_rd1,
               pc:          rob.alloc_pc1
            };
         end
         rv_q    <= {r1, r0};
         head_q  <= head_q + n_ret[IDX_W-1:0];
         tail_q  <= tail_q + n_alloc[IDX_W-1:0];
         count_q <= count_q + n_alloc - n_ret;
      end
   end

   assign rob.alloc_ready    = ready;
   assign rob.alloc_idx0     = tail_q;
   assign rob.alloc_idx1     = tail1;
   assign rob.count          = count_q;
   assign rob.retire_valid   = rv_q;
   assign rob.retire_rd0     = rrd0_q;
   assign rob.retire_rd1     = rrd1_q;
   assign rob.retire_old_rd0 = rold0_q;
   assign rob.retire_old_rd1 = rold1_q;
   assign rob.retire_pc0     = rpc0_q;
   assign rob.retire_pc1     = rpc1_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench: directed scenarios plus random traffic,
// checked against an in-order queue model of the ROB.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic flush;

   always #5 clk = ~clk;

   reorder_buffer_if rif();

   reorder_buffer dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .rob   (rif)
   );

   typedef struct {
      int    tag;
      preg_t rd;
      preg_t od;
      pc_t   pc;
      bit    done;
   } ent_t;

   ent_t q[$];
   int   m_tail;
   int   total = 0;
   int   bad   = 0;

   logic [1:0]        e_rv;
   preg_t             e_rd0, e_rd1, e_od0, e_od1;
   pc_t               e_pc0, e_pc1;

   logic [1:0]        s_req;
   preg_t             s_rd0, s_rd1, s_od0, s_od1;
   pc_t               s_pc0, s_pc1;
   logic [NUM_FU-1:0] s_cv;
   rob_idx_t          s_ci [NUM_FU];
   logic              s_fl, s_rs;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      s_req = 2'b00;
      s_cv  = '0;
      s_fl  = 1'b0;
      s_rs  = 1'b0;
      for (int k = 0; k < NUM_FU; k++) s_ci[k] = '0;
   endtask

   task automatic set_alloc(input logic [1:0] rq, input int rd0, rd1,
                            input int od0, od1, input pc_t pc0, pc1);
      s_req = rq;
      s_rd0 = preg_t'(rd0);
      s_rd1 = preg_t'(rd1);
      s_od0 = preg_t'(od0);
      s_od1 = preg_t'(od1);
      s_pc0 = pc0;
      s_pc1 = pc1;
   endtask

   // Request completion of the oldest not-yet-done entries.
   task automatic complete_first(input int n);
      int k = 0;
      foreach (q[i]) begin
         if (k < n && !q[i].done) begin
            s_cv[k] = 1'b1;
            s_ci[k] = rob_idx_t'(q[i].tag);
            k++;
         end
      end
   endtask

   task automatic push_ent(input preg_t rd, od, input pc_t pc);
      ent_t e;
      e.tag  = m_tail;
      e.rd   = rd;
      e.od   = od;
      e.pc   = pc;
      e.done = 1'b0;
      q.push_back(e);
      m_tail = (m_tail + 1) % ROB_DEPTH;
   endtask

   // One clock: drive, check combinational outputs, advance the
   // model from the pre-edge state, then check registered outputs.
   task automatic tick();
      bit r0, r1, rdy;
      @(negedge clk);
      reset             = s_rs;
      flush             = s_fl;
      rif.alloc_req     = s_req;
      rif.alloc_rd0     = s_rd0;
      rif.alloc_rd1     = s_rd1;
      rif.alloc_old_rd0 = s_od0;
      rif.alloc_old_rd1 = s_od1;
      rif.alloc_pc0     = s_pc0;
      rif.alloc_pc1     = s_pc1;
      rif.cmpl_valid    = s_cv;
      rif.cmpl_idx      = {s_ci[2], s_ci[1], s_ci[0]};
      #1;
      rdy = (q.size() <= ROB_DEPTH - 2);
      chk("alloc_ready", rif.alloc_ready, rdy);
      chk("alloc_idx0", rif.alloc_idx0, m_tail % ROB_DEPTH);
      chk("alloc_idx1", rif.alloc_idx1, (m_tail + 1) % ROB_DEPTH);
      chk("count_pre", rif.count, q.size());
      if (s_rs || s_fl) begin
         q.delete();
         m_tail = 0;
         e_rv   = '0;
         e_rd0  = '0; e_rd1 = '0;
         e_od0  = '0; e_od1 = '0;
         e_pc0  = '0; e_pc1 = '0;
      end else begin
         r0 = q.size() > 0 && q[0].done;
         r1 = r0 && q.size() > 1 && q[1].done;
         for (int k = 0; k < NUM_FU; k++) begin
            if (s_cv[k]) begin
               foreach (q[i]) if (q[i].tag == int'(s_ci[k])) q[i].done = 1'b1;
            end
         end
         if (r0) begin
            e_rd0 = q[0].rd; e_od0 = q[0].od; e_pc0 = q[0].pc;
            void'(q.pop_front());
         end
         if (r1) begin
            e_rd1 = q[0].rd; e_od1 = q[0].od; e_pc1 = q[0].pc;
            void'(q.pop_front());
         end
         e_rv = {r1, r0};
         if (rdy && (s_req == 2'b01 || s_req == 2'b11)) begin
            push_ent(s_rd0, s_od0, s_pc0);
            if (s_req == 2'b11) push_ent(s_rd1, s_od1, s_pc1);
         end
      end
      @(posedge clk);
      #1;
      chk("count", rif.count, q.size());
      chk("retire_valid", rif.retire_valid, e_rv);
      chk("retire_rd0", rif.retire_rd0, e_rd0);
      chk("retire_rd1", rif.retire_rd1, e_rd1);
      chk("retire_old_rd0", rif.retire_old_rd0, e_od0);
      chk("retire_old_rd1", rif.retire_old_rd1, e_od1);
      chk("retire_pc0", rif.retire_pc0, e_pc0);
      chk("retire_pc1", rif.retire_pc1, e_pc1);
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && q.size() > 0; n++) begin
         idle();
         complete_first(NUM_FU);
         tick();
      end
      idle();
      tick();
   endtask

   initial begin
      idle();
      set_alloc(2'b00, 0, 0, 0, 0, 32'h0, 32'h0);
      reset             = 1'b1;
      flush             = 1'b0;
      rif.alloc_req     = '0;
      rif.alloc_rd0     = '0;
      rif.alloc_rd1     = '0;
      rif.alloc_old_rd0 = '0;
      rif.alloc_old_rd1 = '0;
      rif.alloc_pc0     = '0;
      rif.alloc_pc1     = '0;
      rif.cmpl_valid    = '0;
      rif.cmpl_idx      = '0;
      m_tail = 0;
      e_rv   = '0;
      e_rd0  = '0; e_rd1 = '0;
      e_od0  = '0; e_od1 = '0;
      e_pc0  = '0; e_pc1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_count", rif.count, 0);
      chk("rst_ready", rif.alloc_ready, 1);
      chk("rst_rv", rif.retire_valid, 0);
      chk("rst_pc0", rif.retire_pc0, 0);

      // First pair gets tags 0 and 1.
      idle();
      set_alloc(2'b11, 10, 11, 1, 2, 32'h100, 32'h104);
      tick();
      chk("pair_count", rif.count, 2);

      // Younger completes first: nothing retires.
      idle();
      s_cv[0] = 1'b1; s_ci[0] = 6'd1;
      tick();
      chk("young_only", rif.retire_valid, 0);
      idle();
      s_cv[1] = 1'b1; s_ci[1] = 6'd0;
      tick();
      chk("head_cmpl_same_edge", rif.retire_valid, 0);
      idle();
      tick();
      chk("dual_rv", rif.retire_valid, 2'b11);
      chk("dual_old0", rif.retire_old_rd0, 1);
      chk("dual_old1", rif.retire_old_rd1, 2);
      chk("dual_pc0", rif.retire_pc0, 32'h100);
      chk("dual_pc1", rif.retire_pc1, 32'h104);
      chk("dual_count", rif.count, 0);

      // Fill to full, then a dropped request.
      for (int i = 0; i < 31; i++) begin
         idle();
         set_alloc(2'b11, i, i + 1, i + 2, i + 3, 32'h1000 + 8 * i, 32'h1004 + 8 * i);
         tick();
      end
      chk("fill62", rif.count, 62);
      chk("fill62_ready", rif.alloc_ready, 1);
      idle();
      set_alloc(2'b11, 5, 6, 7, 8, 32'h2000, 32'h2004);
      tick();
      chk("full_count", rif.count, 64);
      chk("full_ready", rif.alloc_ready, 0);
      idle();
      set_alloc(2'b11, 9, 9, 9, 9, 32'h3000, 32'h3004);
      tick();
      chk("drop_count", rif.count, 64);
      chk("drop_tail", rif.alloc_idx0, 2);
      drain();

      // Walk the pointers to 63, then straddle the wrap.
      for (int n = 0; n < 100 && m_tail != 63; n++) begin
         idle();
         set_alloc(2'b01, n, 0, n + 1, 0, 32'h4000 + 4 * n, 32'h0);
         complete_first(NUM_FU);
         tick();
      end
      drain();
      chk("wrap_idx0", rif.alloc_idx0, 63);
      chk("wrap_idx1", rif.alloc_idx1, 0);
      idle();
      set_alloc(2'b11, 20, 21, 22, 23, 32'hA00, 32'hA04);
      tick();
      idle();
      s_cv[0] = 1'b1; s_ci[0] = 6'd0;
      s_cv[2] = 1'b1; s_ci[2] = 6'd63;
      tick();
      idle();
      tick();
      chk("wrap_rv", rif.retire_valid, 2'b11);
      chk("wrap_pc0", rif.retire_pc0, 32'hA00);
      chk("wrap_pc1", rif.retire_pc1, 32'hA04);

      // Retire and allocate on the same edge at count 10.
      for (int i = 0; i < 5; i++) begin
         idle();
         set_alloc(2'b11, i, i, i, i, 32'h5000 + 8 * i, 32'h5004 + 8 * i);
         tick();
      end
      idle();
      complete_first(1);
      tick();
      chk("c10_count", rif.count, 10);
      idle();
      set_alloc(2'b11, 30, 31, 32, 33, 32'h6000, 32'h6004);
      tick();
      chk("c10_next", rif.count, 11);
      chk("c10_rv", rif.retire_valid, 2'b01);

      // Flush with five in flight; stale completions ignored.
      idle(); s_fl = 1'b1; tick();
      idle(); set_alloc(2'b11, 1, 2, 3, 4, 32'h7000, 32'h7004); tick();
      idle(); set_alloc(2'b11, 5, 6, 7, 8, 32'h7008, 32'h700C); tick();
      idle(); set_alloc(2'b01, 9, 0, 10, 0, 32'h7010, 32'h0); tick();
      chk("fl_count5", rif.count, 5);
      idle();
      s_fl = 1'b1;
      set_alloc(2'b11, 1, 1, 1, 1, 32'h1, 32'h1);
      s_cv = 3'b111; s_ci[0] = 6'd0; s_ci[1] = 6'd1; s_ci[2] = 6'd2;
      tick();
      chk("fl_count", rif.count, 0);
      chk("fl_rv", rif.retire_valid, 0);
      idle();
      s_cv = 3'b111; s_ci[0] = 6'd0; s_ci[1] = 6'd1; s_ci[2] = 6'd2;
      tick();
      idle();
      tick();
      chk("fl_late_rv", rif.retire_valid, 0);
      chk("fl_idx0", rif.alloc_idx0, 0);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 3000; i++) begin
         int pct;
         idle();
         pct  = ((i / 300) % 2) ? 8 : 3;
         s_rs = ($urandom_range(0, 499) == 0);
         s_fl = ($urandom_range(0, 199) == 0);
         set_alloc(2'($urandom_range(0, 3)), $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom);
         for (int k = 0; k < NUM_FU; k++) begin
            s_cv[k] = ($urandom_range(0, 9) < pct);
            if (q.size() > 0 && $urandom_range(0, 9) != 0)
               s_ci[k] = rob_idx_t'(q[$urandom_range(0, q.size() - 1)].tag);
            else
               s_ci[k] = rob_idx_t'($urandom_range(0, ROB_DEPTH - 1));
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
